vga_timing_gen: RTL
===================

# vga_timing_gen

Parametrised VGA raster timing generator; successor to the fixed 640x480 `vga` block feeding `pattern_gen`. Produces hsync/vsync, pixel column/row, active-video `valid`, and one-cycle frame/line start strobes. All porch/sync widths and sync polarity are set by parameters. A pixel-enable input lets it run from a faster system clock. An optional frame counter drives game-animation timing.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16; `H_SYNC`, 96; `H_BP`, 48: horizontal front porch, sync and back porch, in pixels
- `V_ACTIVE`, 480: visible lines
- `V_FP`, 10; `V_SYNC`, 2; `V_BP`, 33: vertical front porch, sync and back porch, in lines
- `SYNC_POL`, 0: asserted sync level; 0 = active-low
- `CNT_W`, 10: width of the col/row counters
- `FRAME_W`, 8: width of the frame counter
- `clk`  in  1  pixel/system clock
- `reset`  in  1  asynchronous, active-high reset
- `enable`  in  1  pixel strobe; the counters advance only on clk edges where it is 1 (tie high for 1 px/clk)
- `hsync`  out  1  horizontal sync
- `vsync`  out  1  vertical sync
- `col`  out  CNT_W  current pixel column, 0..H_TOTAL-1
- `row`  out  CNT_W  current line, 0..V_TOTAL-1
- `valid`  out  1  high when col < H_ACTIVE and row < V_ACTIVE
- `frame_start`  out  1  one-clk pulse on entering (0,0)
- `line_start`  out  1  one-clk pulse on entering col 0 (any row)
- `frame_count`  out  FRAME_W  frame index; present only with the configuration macro

## Operation
- Totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP
- Elaboration `$error` if H_TOTAL-1 or V_TOTAL-1 does not fit in CNT_W, or if any parameter is 0.
- On a clk edge with `enable`=1:
  - col increments; at H_TOTAL-1 it wraps to 0 and row increments.
  - When row is at V_TOTAL-1 and col wraps, row wraps to 0.
- `enable`=0: every register holds; `frame_start` and `line_start` are driven 0.
- hsync is asserted (=SYNC_POL) when H_ACTIVE+H_FP <= col < H_ACTIVE+H_FP+H_SYNC; otherwise it is at the inactive level.
- vsync is asserted when V_ACTIVE+V_FP <= row < V_ACTIVE+V_FP+V_SYNC, over whole lines, changing only at col wrap.
- All outputs are registered and decoded from next-state counts, so hsync/vsync/valid/strobes are coherent with the col/row presented in the same cycle.
- Reset values:
  - col=H_TOTAL-1, row=V_TOTAL-1 (last back-porch pixel)
  - valid=0, hsync=vsync=inactive level
  - frame_start=line_start=0, frame_count=all ones
- First enabled edge after reset: col=0, row=0, valid=1, frame_start=1, line_start=1, frame_count=0.
- Reset asserted mid-frame: outputs go to reset values immediately, without waiting for a clk edge; the raster restarts from the state above.

## Timing
- Latency from `enable` edge to the new col/row and all decodes: 1 clk, all outputs together.
- `frame_start`/`line_start` are high for exactly one clk: the cycle following the enabling edge that loaded col 0. Sparse `enable` never stretches them.
- `frame_start` implies `line_start` in the same cycle.
- `frame_count` updates on the same edge that sets `frame_start`, and wraps 2^FRAME_W-1 -> 0.
- Period: one `frame_start` per H_TOTAL*V_TOTAL enabled edges.

## Configuration
- `VGA_FRAME_COUNT_EN` defined: the `frame_count` register and port exist, with the behaviour above.
- Not defined: the port is still present but tied to 0; no register is inferred.

## Test plan
All scenarios use small parameters H 4/1/2/1 (H_TOTAL 8) and V 3/1/1/1 (V_TOTAL 6), SYNC_POL 0, `enable`=1 unless stated.
- Reset release:
  - During reset: col=7, row=5, valid=0, hsync=vsync=1.
  - First edge: (0,0), valid=1, frame_start=line_start=1, frame_count=0.
- One line: col runs 0..7.
  - valid=1 for col 0..3.
  - hsync=0 exactly for col 5,6.
  - line_start=1 only at col 0.
- Full frame: 48 edges between frame_start pulses.
  - vsync=0 for all 8 pixels of row 4 only.
  - frame_count increments by 1 per frame and wraps 255 -> 0.
- `enable` at 1-in-4 clks:
  - Counters advance once per strobe.
  - frame_start is a single clk wide.
  - Outputs are frozen between strobes.
- Async reset at (2,1): outputs take reset values before the next clk edge; the next enabled edge after release gives (0,0) with frame_start=1.
- Macro undefined: frame_count stays 0 over 3 frames; all other outputs are identical to the macro-defined run.

Source files
------------

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator with pixel-enable
// Optional frame counter register enabled by defining VGA_FRAME_COUNT_EN.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0,
    parameter int   CNT_W    = 10,
    parameter int   FRAME_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    output logic               hsync,
    output logic               vsync,
    output logic [CNT_W-1:0]   col,
    output logic [CNT_W-1:0]   row,
    output logic               valid,
    output logic               frame_start,
    output logic               line_start,
    output logic [FRAME_W-1:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
            V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
            CNT_W == 0 || FRAME_W == 0) begin : g_zero_param
            $error("vga_timing_gen: parameters must be non-zero");
        end
        if ((H_TOTAL - 1) >= (2 ** CNT_W) || (V_TOTAL - 1) >= (2 ** CNT_W)) begin : g_cnt_width
            $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
        end
    endgenerate

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] col_n;
    logic [CNT_W-1:0] row_n;
    logic             col_wrap;
    logic             hsync_n;
    logic             vsync_n;
    logic             valid_n;
    logic             line_n;
    logic             frame_n;

    // Decodes are taken from the next counts so every registered output lines up with col/row.
    always_comb begin
        col_wrap = (col == H_LAST);
        col_n    = col_wrap ? '0 : col + CNT_W'(1);
        row_n    = row;
        if (col_wrap) begin
            row_n = (row == V_LAST) ? '0 : row + CNT_W'(1);
        end
        hsync_n = ((col_n >= HS_START) && (col_n < HS_END)) ? SYNC_POL : ~SYNC_POL;
        vsync_n = ((row_n >= VS_START) && (row_n < VS_END)) ? SYNC_POL : ~SYNC_POL;
        valid_n = (col_n < H_VIS) && (row_n < V_VIS);
        line_n  = (col_n == '0);
        frame_n = line_n && (row_n == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col         <= H_LAST;
            row         <= V_LAST;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            valid       <= 1'b0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            if (enable) begin
                col         <= col_n;
                row         <= row_n;
                hsync       <= hsync_n;
                vsync       <= vsync_n;
                valid       <= valid_n;
                frame_start <= frame_n;
                line_start  <= line_n;
            end
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [FRAME_W-1:0] frame_q;

    // Starts at all ones so the first frame after reset is numbered 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_q <= '1;
        end else if (enable && frame_n) begin
            frame_q <= frame_q + FRAME_W'(1);
        end
    end

    assign frame_count = frame_q;
`else
    assign frame_count = '0;
`endif

endmodule
